// File: rtl/spy_path_sampler.sv
// ============================================================================
// Module  : spy_path_sampler
// Brief   : Launch/capture controller for a chained spy delay path; counts
//           capture mismatches over a programmed number of trials.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module spy_path_sampler #(
    parameter int   CNT_W         = 16,
    parameter int   WAIT_W        = 8,
    parameter int   SETTLE_CYCLES = 16,
    parameter logic PATH_PARITY   = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  trials,
    input  logic [WAIT_W-1:0] waitCycles,
    output logic              pathInput,
    input  logic              pathResult,
    output logic              busy,
    output logic              lastSample,
    output logic [CNT_W-1:0]  errCount,
    output logic              resultValid,
    input  logic              resultReady
);

    localparam int c_SETTLE_W = $clog2(SETTLE_CYCLES) + 1;
    localparam logic [c_SETTLE_W-1:0] c_SETTLE_LOAD = c_SETTLE_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LAUNCH  = 3'd1,
        S_WAIT    = 3'd2,
        S_CAPTURE = 3'd3,
        S_SETTLE  = 3'd4,
        S_REPORT  = 3'd5
    } state_t;

    state_t                state_q,      state_d;
    logic                  pathInput_q,  pathInput_d;
    logic                  lastSample_q, lastSample_d;
    logic [CNT_W-1:0]      errCount_q,   errCount_d;
    logic [CNT_W-1:0]      trials_q,     trials_d;
    logic [CNT_W-1:0]      trialCnt_q,   trialCnt_d;
    logic [WAIT_W-1:0]     waitLen_q,    waitLen_d;
    logic [WAIT_W-1:0]     waitCnt_q,    waitCnt_d;
    logic [c_SETTLE_W-1:0] settleCnt_q,  settleCnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pathInput_q  <= 1'b0;
            lastSample_q <= 1'b0;
            errCount_q   <= '0;
            trials_q     <= '0;
            trialCnt_q   <= '0;
            waitLen_q    <= '0;
            waitCnt_q    <= '0;
            settleCnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            pathInput_q  <= pathInput_d;
            lastSample_q <= lastSample_d;
            errCount_q   <= errCount_d;
            trials_q     <= trials_d;
            trialCnt_q   <= trialCnt_d;
            waitLen_q    <= waitLen_d;
            waitCnt_q    <= waitCnt_d;
            settleCnt_q  <= settleCnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pathInput_d  = pathInput_q;
        lastSample_d = lastSample_q;
        errCount_d   = errCount_q;
        trials_d     = trials_q;
        trialCnt_d   = trialCnt_q;
        waitLen_d    = waitLen_q;
        waitCnt_d    = waitCnt_q;
        settleCnt_d  = settleCnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    trials_d   = trials;
                    waitLen_d  = waitCycles;
                    errCount_d = '0;
                    trialCnt_d = '0;
                    state_d    = (trials == '0) ? S_REPORT : S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                pathInput_d = ~pathInput_q;
                waitCnt_d   = waitLen_q;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                // Raw single-flop capture: metastability is part of what is measured.
                if (waitCnt_q == '0) begin
                    lastSample_d = pathResult;
                    state_d      = S_CAPTURE;
                end else begin
                    waitCnt_d = waitCnt_q - WAIT_W'(1);
                end
            end
            S_CAPTURE: begin
                if ((lastSample_q != (pathInput_q ^ PATH_PARITY)) && (errCount_q != '1)) begin
                    errCount_d = errCount_q + CNT_W'(1);
                end
                trialCnt_d  = trialCnt_q + CNT_W'(1);
                settleCnt_d = c_SETTLE_LOAD;
                state_d     = S_SETTLE;
            end
            S_SETTLE: begin
                if (settleCnt_q == '0) begin
                    state_d = (trialCnt_q == trials_q) ? S_REPORT : S_LAUNCH;
                end else begin
                    settleCnt_d = settleCnt_q - c_SETTLE_W'(1);
                end
            end
            S_REPORT: begin
                if (resultReady) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign pathInput   = pathInput_q;
    assign lastSample  = lastSample_q;
    assign errCount    = errCount_q;
    assign busy        = (state_q != S_IDLE);
    assign resultValid = (state_q == S_REPORT);

endmodule

`default_nettype wire

// File: doc/spy_path_sampler.md
Name: spy_path_sampler

Overview:
- Launch/capture controller that sits at both ends of a chained spy delay path.
- Drives a transition into the path input, samples the path output a programmable number of clocks later, and checks the sample against the expected settled value.
- Repeats for a programmed number of trials and reports the mismatch count with a valid/ready handshake.
- Instantiated next to each chained-path instance, e.g. a 100-stage NOT chain (even inversion count, parity 0).

Parameters:
- CNT_W, 16, width of the trial counter and the error counter.
- WAIT_W, 8, width of the launch-to-capture wait value.
- SETTLE_CYCLES, 16, idle clocks after each capture before the next launch; must be ≥1.
- PATH_PARITY, 0, 1 when the chained path inverts overall (odd NOT count), else 0.

Ports:
- clk, input, 1, single clock.
- rst, input, 1, asynchronous active-high reset.
- start, input, 1, one-cycle request to begin a measurement run.
- trials, input, CNT_W, number of launch/capture trials, latched on start.
- waitCycles, input, WAIT_W, launch-to-capture distance, latched on start.
- pathInput, output, 1, launch signal driven into the chained path.
- pathResult, input, 1, output of the chained path; asynchronous to the launch timing by design.
- busy, output, 1, high from accepted start until the result handshake completes.
- lastSample, output, 1, most recent captured pathResult value.
- errCount, output, CNT_W, mismatches counted in the current or last run.
- resultValid, output, 1, result available.
- resultReady, input, 1, consumer accepts the result.

Behaviour:
- Reset (async, any state): pathInput=0, busy=0, lastSample=0, errCount=0, resultValid=0; internal counters cleared; state=IDLE. Reset mid-run abandons the run with no partial report.
- States: IDLE, LAUNCH, WAIT, CAPTURE, SETTLE, REPORT.
- IDLE:
  - start=1 latches trials, waitCycles and PATH_PARITY expectation, clears errCount and the trial counter, and sets busy=1.
  - Next state is LAUNCH, or REPORT if the latched trials=0.
  - start outside IDLE is ignored.
- LAUNCH (1 cycle): at the edge leaving LAUNCH, pathInput toggles and waitCnt<=waitCycles; next state WAIT.
- WAIT:
  - Each edge: if waitCnt==0, lastSample<=pathResult and go to CAPTURE; else waitCnt decrements.
  - The sample is taken exactly waitCycles+1 edges after the toggle edge; waitCycles=0 samples on the first edge after the toggle.
  - pathResult is registered by a single flop with no synchronizer. Metastability is accepted as part of the measurement.
- CAPTURE (1 cycle):
  - Expected value = pathInput XOR PATH_PARITY.
  - Mismatch: errCount increments, saturating at all-ones.
  - Trial counter increments; next state SETTLE with the settle counter loaded to SETTLE_CYCLES-1.
- SETTLE:
  - Counts down; at 0, go to REPORT if trial counter==latched trials, else LAUNCH.
  - This guarantees the chain is quiescent before the next opposite-polarity launch.
- REPORT:
  - resultValid=1, with errCount and lastSample stable.
  - Held until resultReady=1 is sampled high; at that edge resultValid=0, busy=0, state=IDLE.
  - start in the same cycle is ignored.
  - errCount and lastSample hold their values in IDLE until the next accepted start.
- pathInput polarity alternates every trial and is never reset between runs. A run therefore begins from the level left by the previous run.
- Trial counter wrap cannot occur: trials ≤ 2^CNT_W-1 and the counter stops at equality.

Test Plan:
- Bench models the path as a pure delay of D clocks, non-inverting, PATH_PARITY=0.
- D=3, trials=4, waitCycles=10 → errCount=0, resultValid rises once, pathInput ends at 0 after 4 toggles, busy falls the cycle after resultReady.
- D=5, trials=4, waitCycles=1 → every sample is the stale level, errCount=4; lastSample equals the pre-toggle level of the final trial.
- trials=0 with start → REPORT reached with no pathInput toggle, errCount=0, resultValid=1 within 2 cycles.
- resultReady held low 5 cycles in REPORT → resultValid and errCount stay constant; a start pulse during this time is ignored; the handshake then returns to IDLE.
- Assert rst while in WAIT of trial 2 → all outputs return to reset values immediately (asynchronous); the next start runs cleanly from pathInput=0.
- CNT_W=4, trials=15, D>waitCycles+1 → errCount saturates at 15 and does not wrap; a parity check with PATH_PARITY=1 and an inverting model gives errCount=0.
